// File: rtl/tx_result_packer.sv
// tx_result_packer
// Captures one ALU result or one register-read byte per strobe and
// serialises it into byte-wide TX FIFO writes under fifo_full backpressure.
// Optional feature macro: TX_RESULT_TAG_EN (prefixes every frame with a tag
// byte identifying ALU vs. read frames).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for a strobe; only state in which strobes are taken
// SEND_TAG | presenting the frame tag byte (TX_RESULT_TAG_EN builds only)
// SEND_LO  | presenting ALU result low byte
// SEND_HI  | presenting ALU result high byte (last byte of ALU frame)
// SEND_RD  | presenting read-data byte (last byte of read frame)

module tx_result_packer #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ALU_OUT_W  = 16,
    parameter logic [DATA_WIDTH-1:0] TAG_ALU    = 8'hA5,
    parameter logic [DATA_WIDTH-1:0] TAG_RD     = 8'h5A
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [ALU_OUT_W-1:0]  ALU_OUT,
    input  logic                  OUT_Valid,
    input  logic [DATA_WIDTH-1:0] RdData,
    input  logic                  RdData_Valid,
    input  logic                  fifo_full,
    input  logic                  OVF_CLR,
    output logic [DATA_WIDTH-1:0] WR_DATA,
    output logic                  WR_INC,
    output logic                  BUSY,
    output logic                  OVF,
    output logic [7:0]            FRAME_CNT
);

    // The byte split below assumes exactly two bytes per ALU result, and a
    // tag parser downstream can only tell frames apart if the tags differ.
    if (ALU_OUT_W != 2 * DATA_WIDTH || TAG_ALU == TAG_RD) begin : g_bad_cfg
        $error("tx_result_packer: ALU_OUT_W must be 2*DATA_WIDTH and tags must differ");
    end

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SEND_LO = 3'd1;
    localparam logic [2:0] S_SEND_HI = 3'd2;
    localparam logic [2:0] S_SEND_RD = 3'd3;
`ifdef TX_RESULT_TAG_EN
    localparam logic [2:0] S_SEND_TAG = 3'd4;
`endif

    logic [2:0]           state_q, state_d;
    logic [ALU_OUT_W-1:0] hold_q, hold_d;
    logic                 ovf_q, ovf_d;
    logic [7:0]           cnt_q, cnt_d;
`ifdef TX_RESULT_TAG_EN
    // Remembers frame kind so SEND_TAG can pick the tag and the next state.
    logic                 kind_rd_q, kind_rd_d;
`endif

    logic wr_inc;
    logic [DATA_WIDTH-1:0] wr_data;
    logic idle;
    logic frame_done;
    logic drop;

    assign idle = (state_q == S_IDLE);

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: strobes only matter in IDLE, SEND_* advance on a write
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
`ifdef TX_RESULT_TAG_EN
                if (RdData_Valid || OUT_Valid) begin
                    state_d = S_SEND_TAG;
                end
`else
                if (RdData_Valid) begin
                    state_d = S_SEND_RD;
                end else if (OUT_Valid) begin
                    state_d = S_SEND_LO;
                end
`endif
            end
`ifdef TX_RESULT_TAG_EN
            S_SEND_TAG: if (wr_inc) state_d = kind_rd_q ? S_SEND_RD : S_SEND_LO;
`endif
            S_SEND_LO:  if (wr_inc) state_d = S_SEND_HI;
            S_SEND_HI:  if (wr_inc) state_d = S_IDLE;
            S_SEND_RD:  if (wr_inc) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Output logic: byte select and write enable depend only on state and
    // registered data, so strobes never reach WR_INC combinationally
    always_comb begin
        wr_data = '0;
        wr_inc  = 1'b0;
        case (state_q)
`ifdef TX_RESULT_TAG_EN
            S_SEND_TAG: begin
                wr_data = kind_rd_q ? TAG_RD : TAG_ALU;
                wr_inc  = !fifo_full;
            end
`endif
            S_SEND_LO: begin
                wr_data = hold_q[DATA_WIDTH-1:0];
                wr_inc  = !fifo_full;
            end
            S_SEND_HI: begin
                wr_data = hold_q[ALU_OUT_W-1:DATA_WIDTH];
                wr_inc  = !fifo_full;
            end
            S_SEND_RD: begin
                wr_data = hold_q[DATA_WIDTH-1:0];
                wr_inc  = !fifo_full;
            end
            default: begin
                wr_data = '0;
                wr_inc  = 1'b0;
            end
        endcase
    end

    assign frame_done = wr_inc && (state_q == S_SEND_HI || state_q == S_SEND_RD);

    // A strobe is lost if we are busy, or if both arrive together in IDLE
    // (read wins, ALU result is the one dropped).
    assign drop = (!idle && (OUT_Valid || RdData_Valid)) ||
                  (idle && OUT_Valid && RdData_Valid);

    // Datapath next values: capture, overflow flag, frame counter
    always_comb begin
        hold_d = hold_q;
        if (idle) begin
            if (RdData_Valid) begin
                hold_d = {{(ALU_OUT_W-DATA_WIDTH){1'b0}}, RdData};
            end else if (OUT_Valid) begin
                hold_d = ALU_OUT;
            end
        end

        if (drop) begin
            ovf_d = 1'b1;
        end else if (OVF_CLR) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end

        cnt_d = frame_done ? cnt_q + 8'd1 : cnt_q;
    end

`ifdef TX_RESULT_TAG_EN
    // Frame kind latched alongside the data capture
    always_comb begin
        kind_rd_d = kind_rd_q;
        if (idle && (RdData_Valid || OUT_Valid)) begin
            kind_rd_d = RdData_Valid;
        end
    end

    // Frame kind register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            kind_rd_q <= 1'b0;
        end else begin
            kind_rd_q <= kind_rd_d;
        end
    end
`endif

    // Datapath registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hold_q <= '0;
            ovf_q  <= 1'b0;
            cnt_q  <= 8'd0;
        end else begin
            hold_q <= hold_d;
            ovf_q  <= ovf_d;
            cnt_q  <= cnt_d;
        end
    end

    assign WR_DATA   = wr_data;
    assign WR_INC    = wr_inc;
    assign BUSY      = !idle;
    assign OVF       = ovf_q;
    assign FRAME_CNT = cnt_q;

endmodule

// File: tb/tb_tx_result_packer.sv
// Self-checking bench for tx_result_packer: expected FIFO bytes are queued
// by the stimulus thread and consumed by an independent write monitor.
// Build with +define+TX_RESULT_TAG_EN to exercise the tagged frame format.

module tb_tx_result_packer;

`ifdef TX_RESULT_TAG_EN
    localparam int NB_ALU = 3;
    localparam int NB_RD  = 2;
    localparam logic [7:0] T_ALU = 8'hA5;
    localparam logic [7:0] T_RD  = 8'h5A;
    localparam bit TAGGED = 1'b1;
`else
    localparam int NB_ALU = 2;
    localparam int NB_RD  = 1;
    localparam logic [7:0] T_ALU = 8'h00;
    localparam logic [7:0] T_RD  = 8'h00;
    localparam bit TAGGED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] alu_out;
    logic        out_valid;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        fifo_full;
    logic        ovf_clr;
    logic [7:0]  wr_data;
    logic        wr_inc;
    logic        busy;
    logic        ovf;
    logic [7:0]  frame_cnt;

    int total = 0;
    int bad   = 0;
    int writes = 0;
    logic [7:0] exp_q[$];

    tx_result_packer dut (
        .CLK          (clk),
        .RST          (rst),
        .ALU_OUT      (alu_out),
        .OUT_Valid    (out_valid),
        .RdData       (rd_data),
        .RdData_Valid (rd_valid),
        .fifo_full    (fifo_full),
        .OVF_CLR      (ovf_clr),
        .WR_DATA      (wr_data),
        .WR_INC       (wr_inc),
        .BUSY         (busy),
        .OVF          (ovf),
        .FRAME_CNT    (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Write monitor: every FIFO write must match the next queued byte
    always @(negedge clk) begin
        if (wr_inc === 1'b1) begin
            writes++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write: got %0h expected no write", wr_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (wr_data !== e) begin
                    bad++;
                    $display("FAIL write_byte: got %0h expected %0h", wr_data, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_alu(input logic [15:0] v);
        if (TAGGED) exp_q.push_back(T_ALU);
        exp_q.push_back(v[7:0]);
        exp_q.push_back(v[15:8]);
    endtask

    task automatic push_rd(input logic [7:0] v);
        if (TAGGED) exp_q.push_back(T_RD);
        exp_q.push_back(v);
    endtask

    task automatic pulse_alu(input logic [15:0] v);
        alu_out   = v;
        out_valid = 1'b1;
        tick();
        out_valid = 1'b0;
    endtask

    task automatic pulse_rd(input logic [7:0] v);
        rd_data  = v;
        rd_valid = 1'b1;
        tick();
        rd_valid = 1'b0;
    endtask

    // Waits (bounded) until BUSY is low at a negedge; returns just after it
    task automatic wait_idle(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (busy === 1'b0) done = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        #1;
        if (!done) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got busy expected idle", name);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        rst = 1'b1;
        alu_out = '0; out_valid = 1'b0; rd_data = '0; rd_valid = 1'b0;
        fifo_full = 1'b0; ovf_clr = 1'b0;

        // Reset values
        @(negedge clk);
        check("rst_wr_inc", wr_inc, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_busy", busy, 0);
        check("rst_ovf", ovf, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        tick();
        rst = 1'b0;
        tick();

        // ALU frame 1234
        w0 = writes;
        push_alu(16'h1234);
        pulse_alu(16'h1234);
        @(negedge clk);
        check("alu_first_cycle_wr_inc", wr_inc, 1);
        check("alu_first_cycle_byte", wr_data, TAGGED ? 32'hA5 : 32'h34);
        wait_idle("alu");
        check("alu_writes", writes - w0, NB_ALU);
        check("alu_frame_cnt", frame_cnt, 1);
        check("alu_busy_after", busy, 0);

        // Backpressure on a read frame
        w0 = writes;
        fifo_full = 1'b1;
        push_rd(8'h7E);
        pulse_rd(8'h7E);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_wr_inc_low", wr_inc, 0);
            check("bp_wr_data_held", wr_data, TAGGED ? 32'h5A : 32'h7E);
            tick();
        end
        check("bp_no_writes", writes - w0, 0);
        fifo_full = 1'b0;
        wait_idle("bp");
        check("bp_writes", writes - w0, NB_RD);
        check("bp_frame_cnt", frame_cnt, 2);

        // Simultaneous strobes: read wins, OVF set
        w0 = writes;
        push_rd(8'h3C);
        alu_out = 16'hDEAD;
        out_valid = 1'b1;
        pulse_rd(8'h3C);
        out_valid = 1'b0;
        wait_idle("simul");
        check("simul_writes", writes - w0, NB_RD);
        check("simul_ovf", ovf, 1);
        check("simul_frame_cnt", frame_cnt, 3);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        @(negedge clk);
        check("ovf_clr", ovf, 0);
        tick();

        // Strobe during SEND_HI (the final write edge)
        w0 = writes;
        push_alu(16'hBEEF);
        pulse_alu(16'hBEEF);
        tick();
        if (TAGGED) tick();
        pulse_alu(16'h9999);
        wait_idle("busy_strobe");
        check("busy_strobe_writes", writes - w0, NB_ALU);
        check("busy_strobe_ovf", ovf, 1);
        check("busy_strobe_frame_cnt", frame_cnt, 4);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;

        // Reset mid-frame while in SEND_HI
        if (TAGGED) exp_q.push_back(T_ALU);
        exp_q.push_back(8'h78);
        pulse_alu(16'h5678);
        tick();
        if (TAGGED) tick();
        rst = 1'b1;
        #1;
        check("midrst_wr_inc", wr_inc, 0);
        check("midrst_wr_data", wr_data, 0);
        check("midrst_busy", busy, 0);
        check("midrst_frame_cnt", frame_cnt, 0);
        tick();
        rst = 1'b0;
        w0 = writes;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_no_wr_inc", wr_inc, 0);
            tick();
        end
        check("post_rst_frame_cnt", frame_cnt, 0);
        check("post_rst_queue_empty", exp_q.size(), 0);

        // 256 read frames wrap the counter
        w0 = writes;
        for (int i = 0; i < 256; i++) begin
            push_rd(8'(i));
            pulse_rd(8'(i));
            wait_idle("wrap");
            if (i == 254) check("cnt_255", frame_cnt, 255);
        end
        check("wrap_frame_cnt", frame_cnt, 0);
        check("wrap_writes", writes - w0, 256 * NB_RD);
        check("wrap_ovf", ovf, 0);
        check("final_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tx_result_packer.md
Name: tx_result_packer

Overview:
- Sits directly downstream of the system controller's result outputs, and upstream of the TX async FIFO write port.
- Captures one ALU result (16-bit) or one register-read byte per valid pulse into a holding register.
- Serialises the captured result into 8-bit FIFO writes, honouring fifo_full backpressure.
- Provides busy status, a sticky overflow flag and a wrapping frame counter.

Parameters:
- DATA_WIDTH, 8, FIFO byte width.
- ALU_OUT_W, 16, ALU result width; must equal 2*DATA_WIDTH.
- TAG_ALU, 8'hA5, tag byte for ALU frames (used only with the optional feature).
- TAG_RD, 8'h5A, tag byte for read frames (used only with the optional feature).

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous active-high reset.
- ALU_OUT  in  ALU_OUT_W  ALU result, valid while OUT_Valid=1.
- OUT_Valid  in  1  one-cycle ALU result strobe.
- RdData  in  DATA_WIDTH  register-file read data.
- RdData_Valid  in  1  one-cycle read data strobe.
- fifo_full  in  1  TX FIFO full; write blocked.
- OVF_CLR  in  1  clears OVF.
- WR_DATA  out  DATA_WIDTH  byte presented to FIFO.
- WR_INC  out  1  FIFO write enable; one byte per high cycle.
- BUSY  out  1  frame in progress; new strobes not accepted.
- OVF  out  1  sticky: a strobe was dropped.
- FRAME_CNT  out  8  completed frames, wraps 255->0.

Behaviour:
- Reset (RST=1, asynchronous): state=IDLE, holding register=0, WR_DATA=0, WR_INC=0, BUSY=0, OVF=0, FRAME_CNT=0. Reset mid-frame discards the frame; no partial write is completed.
- States: IDLE, SEND_LO, SEND_HI, SEND_RD. With TAG_EN, an additional state SEND_TAG.
- IDLE:
  - RdData_Valid: capture RdData, go to SEND_RD.
  - Else OUT_Valid: capture ALU_OUT, go to SEND_LO.
  - Both strobes in the same cycle: read wins, ALU strobe dropped, OVF set.
- Latency: strobe sampled at edge N; WR_INC may first assert in the cycle after edge N.
- SEND_* states:
  - WR_DATA = current byte (combinational from state and holding register).
  - WR_INC = !fifo_full (combinational).
  - Advance only on an edge where WR_INC=1; while fifo_full=1, hold state and WR_DATA stable.
- Byte order and frame end:
  - SEND_LO sends ALU_OUT[7:0], then SEND_HI.
  - SEND_HI sends ALU_OUT[15:8], then IDLE.
  - SEND_RD sends RdData, then IDLE.
  - On the last byte's write edge, FRAME_CNT increments (modulo 256).
- BUSY = (state != IDLE).
  - Any strobe arriving while BUSY=1, including on the final write edge, is dropped and sets OVF.
  - Back-to-back frames therefore need at least one IDLE cycle.
- OVF clearing:
  - OVF_CLR=1 clears OVF on the next edge.
  - A simultaneous drop event wins: OVF stays 1.
- No combinational path from the strobes to WR_INC.

Optional Feature:
- Macro: TX_RESULT_TAG_EN.
- Defined: every frame starts with a tag byte sent from SEND_TAG.
  - Tag is TAG_ALU for ALU frames, TAG_RD for read frames.
  - ALU frame = 3 writes; read frame = 2 writes.
  - Tag writes obey the same fifo_full rule as data bytes.
- Undefined: SEND_TAG is absent; ALU frame = 2 writes, read frame = 1 write.

Test Plan:
- ALU frame: OUT_Valid pulse with ALU_OUT=16'h1234, fifo_full=0 -> WR_INC high two consecutive cycles with WR_DATA 8'h34 then 8'h12 (tag build: 8'hA5, 8'h34, 8'h12); FRAME_CNT=1; BUSY low afterward.
- Backpressure: RdData_Valid with RdData=8'h7E, fifo_full=1 for 5 cycles -> WR_INC=0 and WR_DATA=8'h7E held for 5 cycles; exactly one write when fifo_full drops.
- Simultaneous strobes: OUT_Valid and RdData_Valid together, RdData=8'h3C -> single-byte read frame 8'h3C, OVF=1; then OVF_CLR pulse -> OVF=0.
- Strobe while BUSY: second OUT_Valid during SEND_HI -> no extra writes, OVF=1, FRAME_CNT increments by 1 only.
- Reset mid-frame: RST asserted in SEND_HI -> all outputs 0 immediately; after release, no stray WR_INC and FRAME_CNT=0.
- Counter wrap: 256 read frames -> FRAME_CNT returns to 0 with no stall.
